// File: rtl/scc_pkg.sv
// Shared fetch-stage definitions: branch opcodes, queue entry layout, FSM states.
package scc_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_B     = 7'b1100000;
  localparam logic [6:0] OP_BCOND = 7'b1100001;
  localparam logic [6:0] OP_BR    = 7'b1100010;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StRun,
    StWaitCond
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory, branch register read, ID handshake and ID redirect.
interface fetch_unit_if
  import scc_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [2:0]      br_addr;
  logic [XLEN-1:0] br_value;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, br_addr, id_valid, id_instr, id_pc,
    input  imem_data, br_value, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, br_addr, id_valid, id_instr, id_pc,
    output imem_data, br_value, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush; the caller guarantees no push when full.
module fetch_queue
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output entry_t        head_o,
  output logic [PtrW:0] count_o
);
  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, early B/BR resolution, conditional-branch stall,
// and an epoch tag that discards responses fetched down a superseded path.
module fetch_unit
  import scc_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned     CntW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] PcMask = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            epoch_q, epoch_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_epoch_q, inflight_epoch_d;

  logic            resp_kept, is_b, is_br, is_bcond, early_br;
  logic            req, push, pop;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_sext, early_target;
  logic [CntW-1:0] count, credit;
  entry_t          head, push_entry;

  // Response decode; the request made in the capture cycle of an early branch is
  // still issued and later discarded because the epoch flips underneath it.
  always_comb begin
    resp_kept    = inflight_q && (inflight_epoch_q == epoch_q);
    opcode       = bus.imem_data[31:25];
    is_b         = resp_kept && (opcode == OP_B);
    is_br        = resp_kept && (opcode == OP_BR);
    is_bcond     = resp_kept && (opcode == OP_BCOND);
    early_br     = is_b || is_br;
    imm_sext     = {{(XLEN-16){bus.imem_data[15]}}, bus.imem_data[15:0]};
    early_target = ((is_b ? inflight_pc_q : bus.br_value) + imm_sext) & PcMask;
    credit       = count + CntW'(inflight_q);
    req          = (state_q == StRun) && (credit < CntW'(DEPTH)) && !bus.redirect_valid;
    push         = resp_kept && !bus.redirect_valid;
    pop          = bus.id_valid && bus.id_ready;
    push_entry   = '{pc: inflight_pc_q, instr: bus.imem_data};
  end

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q;
    inflight_d       = req;
    inflight_pc_d    = fetch_pc_q;
    inflight_epoch_d = epoch_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & PcMask;
      epoch_d    = ~epoch_q;
    end else if (early_br) begin
      fetch_pc_d = early_target;
      epoch_d    = ~epoch_q;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (is_bcond && !bus.redirect_valid) state_d = StWaitCond;
      StWaitCond: if (bus.redirect_valid) state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StRun;
      fetch_pc_q       <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
    end
  end

  // Outputs are zeroed when nothing is valid so reset and flush present clean values.
  always_comb begin
    bus.imem_req  = req && !reset;
    bus.imem_addr = fetch_pc_q;
    bus.br_addr   = inflight_q ? bus.imem_data[24:22] : 3'b000;
    bus.id_valid  = (count != '0);
    bus.id_instr  = bus.id_valid ? head.instr : '0;
    bus.id_pc     = bus.id_valid ? head.pc : '0;
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed programs, expected ID stream queued up front.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] regs [8];
  exp_t        exp_q [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Instruction memory: registered read, data valid the cycle after the request.
  always @(posedge clk) if (bus.imem_req) bus.imem_data <= mem[bus.imem_addr[9:2]];
  assign bus.br_value = regs[bus.br_addr];

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [31:0] fill(input logic [31:0] pc);
    return 32'h0A00_0000 | {16'h0000, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = fill(32'(i * 4));
  endtask

  task automatic expect_run(input logic [31:0] first, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = first + 32'(4 * i);
      e.instr = mem[e.pc[9:2]];
      exp_q.push_back(e);
    end
  endtask

  task automatic at_drive(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_sample(input int c);
    at_drive(c);
    @(negedge clk);
  endtask

  task automatic begin_reset();
    @(posedge clk);
    #1;
    reset              = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    init_mem();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_id_valid", 32'(bus.id_valid), 0);
    check("rst_id_instr", bus.id_instr, 0);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_imem_req", 32'(bus.imem_req), 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_br_addr", 32'(bus.br_addr), 0);
  endtask

  // Monitor: every accepted head is compared against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_id_pc", bus.id_pc, e.pc);
        check("sb_id_instr", bus.id_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq;
    for (int i = 0; i < 8; i++) regs[i] = 32'(i) * 32'h1000;
    regs[3] = 32'h100;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Straight line with reset values and 2-cycle startup latency
    begin_reset();
    expect_run(32'h0, 8);
    @(negedge clk);
    check_reset_vals();
    release_reset();
    at_sample(0);
    check("start_req", 32'(bus.imem_req), 1);
    check("start_addr", bus.imem_addr, 32'h0);
    check("start_valid_c0", 32'(bus.id_valid), 0);
    at_sample(1);
    check("start_valid_c1", 32'(bus.id_valid), 0);
    at_sample(2);
    check("start_valid_c2", 32'(bus.id_valid), 1);
    at_sample(12);
    check("straight_drained", exp_q.size(), 0);

    // Backpressure: credit limits issues to DEPTH, release drains in order
    begin_reset();
    bus.id_ready = 1'b0;
    expect_run(32'h0, 6);
    release_reset();
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      at_sample(c);
      if (bus.imem_req) nreq++;
    end
    check("bp_issue_count", nreq, 4);
    check("bp_head_valid", 32'(bus.id_valid), 1);
    check("bp_head_pc", bus.id_pc, 32'h0);
    at_drive(10);
    bus.id_ready = 1'b1;
    at_sample(24);
    check("bp_drained", exp_q.size(), 0);

    // B at 0x10, imm -16: target 0x00, fall-through 0x14 never reaches ID
    begin_reset();
    mem[4] = 32'hC000_FFF0;
    expect_run(32'h0, 5);
    expect_run(32'h0, 3);
    release_reset();
    at_sample(4);
    check("b_issue_addr", bus.imem_addr, 32'h10);
    at_sample(6);
    check("b_target_req", 32'(bus.imem_req), 1);
    check("b_target_addr", bus.imem_addr, 32'h0);
    at_sample(7);
    check("b_bubble", 32'(bus.id_valid), 0);
    at_sample(20);
    check("b_drained", exp_q.size(), 0);

    // BR at 0x20 via r3=0x100, imm 6: target 0x104
    begin_reset();
    mem[8] = 32'hC4C0_0006;
    expect_run(32'h0, 9);
    expect_run(32'h104, 2);
    release_reset();
    at_sample(9);
    check("br_addr", 32'(bus.br_addr), 3);
    at_sample(10);
    check("br_target_req", 32'(bus.imem_req), 1);
    check("br_target_addr", bus.imem_addr, 32'h104);
    at_sample(24);
    check("br_drained", exp_q.size(), 0);

    // Bcond at 0x30: fetch stalls, ID redirect to 0x80 flushes the queue
    begin_reset();
    mem[12] = 32'hC200_0000;
    expect_run(32'h0, 12);
    release_reset();
    at_drive(14);
    bus.id_ready = 1'b0;
    nreq = 0;
    for (int c = 14; c < 20; c++) begin
      at_sample(c);
      if (bus.imem_req) nreq++;
      if (c == 16) begin
        check("bc_head_valid", 32'(bus.id_valid), 1);
        check("bc_head_pc", bus.id_pc, 32'h30);
        check("bc_head_instr", bus.id_instr, 32'hC200_0000);
      end
    end
    check("bc_no_req", nreq, 0);
    at_drive(20);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    at_sample(20);
    check("bc_redir_no_req", 32'(bus.imem_req), 0);
    at_drive(21);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    expect_run(32'h80, 3);
    at_sample(21);
    check("bc_flushed", 32'(bus.id_valid), 0);
    check("bc_redir_req", 32'(bus.imem_req), 1);
    check("bc_redir_addr", bus.imem_addr, 32'h80);
    at_sample(32);
    check("bc_drained", exp_q.size(), 0);

    // ID redirect (low bits set) in the same cycle as a B response: ID wins, B dropped
    begin_reset();
    mem[4] = 32'hC000_FFF0;
    expect_run(32'h0, 4);
    expect_run(32'h200, 3);
    release_reset();
    at_drive(5);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h202;
    at_sample(5);
    check("rb_no_req", 32'(bus.imem_req), 0);
    at_drive(6);
    bus.redirect_valid = 1'b0;
    at_sample(6);
    check("rb_req", 32'(bus.imem_req), 1);
    check("rb_addr", bus.imem_addr, 32'h200);
    check("rb_b_dropped", 32'(bus.id_valid), 0);
    at_sample(20);
    check("rb_drained", exp_q.size(), 0);

    // Reset mid-run takes effect immediately; fetch restarts at RESET_PC
    begin_reset();
    expect_run(32'h0, 5);
    release_reset();
    at_drive(7);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    check("mr_drained", exp_q.size(), 0);
    expect_run(32'h0, 3);
    release_reset();
    at_sample(0);
    check("mr_restart_req", 32'(bus.imem_req), 1);
    check("mr_restart_addr", bus.imem_addr, 32'h0);
    at_sample(12);
    check("mr_final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
